// File: rtl/temp_sample_sequencer.sv
// temp_sample_sequencer: sequences ADC sampling into a buffer and streams samples out over the UART
module temp_sample_sequencer #(
  parameter int DEPTH = 8,
  parameter int DATA_W = 12,
  parameter int ADC_TIMEOUT = 1_000_000,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1,
  localparam int TW = $clog2(ADC_TIMEOUT + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_req,
  input  logic              send_req,
  input  logic              clear_req,
  output logic              adc_start,
  input  logic              adc_done,
  input  logic [DATA_W-1:0] adc_data,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
  output logic [CW-1:0]     count,
  output logic [DATA_W-1:0] last_sample,
  output logic              busy,
  output logic              full,
  output logic              err
);
  typedef enum logic [2:0] {IDLE, CONVERT, SEND_HI, SEND_LO, TX_WAIT} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [DATA_W-1:0] last_q, last_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic adc_start_q, adc_start_d, tx_start_q, tx_start_d, busy_q, busy_d;
  logic full_q, full_d, err_q, err_d, lo_q, lo_d, first_q, first_d, mem_we;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] cur;
  logic tmo_end, more, sending;
  assign cur = mem_q[idx_q];
  assign tmo_end = tmo_q == TW'(ADC_TIMEOUT - 1);
  assign more = (CW'(idx_q) + CW'(1)) < count_q;
  assign sending = (state_q == SEND_HI || state_q == SEND_LO) && !tx_busy;
  // state and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      last_q <= '0;
      idx_q <= '0;
      tmo_q <= '0;
      tx_data_q <= '0;
      adc_start_q <= 1'b0;
      tx_start_q <= 1'b0;
      busy_q <= 1'b0;
      full_q <= 1'b0;
      err_q <= 1'b0;
      lo_q <= 1'b0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      last_q <= last_d;
      idx_q <= idx_d;
      tmo_q <= tmo_d;
      tx_data_q <= tx_data_d;
      adc_start_q <= adc_start_d;
      tx_start_q <= tx_start_d;
      busy_q <= busy_d;
      full_q <= full_d;
      err_q <= err_d;
      lo_q <= lo_d;
      first_q <= first_d;
    end
  end
  // sample buffer, written at the current fill level on a completed conversion
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[count_q[AW-1:0]] <= adc_data;
  end
  // next-state: clear beats sample beats send; TX_WAIT skips its first cycle before trusting tx_busy
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:             state_d = clear_req ? IDLE : (sample_req && !full_q) ? CONVERT
                                  : (send_req && count_q != '0) ? SEND_HI : IDLE;
      CONVERT:          state_d = (adc_done || tmo_end) ? IDLE : CONVERT;
      SEND_HI, SEND_LO: state_d = tx_busy ? state_q : TX_WAIT;
      TX_WAIT:          state_d = (first_q || tx_busy) ? TX_WAIT : !lo_q ? SEND_LO : more ? SEND_HI : IDLE;
      default:          state_d = IDLE;
    endcase
  end
  // datapath and output next values
  always_comb begin
    count_d = count_q;
    last_d = last_q;
    err_d = err_q;
    lo_d = lo_q;
    tx_data_d = tx_data_q;
    mem_we = 1'b0;
    idx_d = state_q == IDLE ? '0 : idx_q;
    tmo_d = state_q == CONVERT ? tmo_q + 1'b1 : '0;
    first_d = sending;
    if (state_q == IDLE && clear_req) begin
      count_d = '0;
      last_d = '0;
      err_d = 1'b0;
    end
    if (state_q == CONVERT && adc_done) begin
      mem_we = 1'b1;
      count_d = count_q + 1'b1;
      last_d = adc_data;
    end else if (state_q == CONVERT && tmo_end) begin
      err_d = 1'b1;
    end
    if (sending) begin
      tx_data_d = state_q == SEND_LO ? cur[7:0] : 8'(cur >> 8);
      lo_d = state_q == SEND_LO;
    end
    if (state_q == TX_WAIT && !first_q && !tx_busy && lo_q && more) idx_d = idx_q + 1'b1;
    adc_start_d = state_q == IDLE && state_d == CONVERT;
    tx_start_d = sending;
    busy_d = state_d != IDLE;
    full_d = count_d == CW'(DEPTH);
  end
  assign adc_start = adc_start_q;
  assign tx_start = tx_start_q;
  assign tx_data = tx_data_q;
  assign count = count_q;
  assign last_sample = last_q;
  assign busy = busy_q;
  assign full = full_q;
  assign err = err_q;
endmodule

// File: doc/temp_sample_sequencer.md
# temp_sample_sequencer

Sequences temperature acquisition and transmission for the measurement front panel. It consumes the one-cycle SAMPLE, SEND and RESET button pulses from the keyboard button selector, and drives the sensor ADC start/done handshake. Samples are stored in a small internal buffer and streamed out byte-by-byte over the UART transmitter. It sits between the selector/display layer and the ADC and UART datapaths, and is the only block that issues ADC starts or UART bytes.

## Interface
Parameters:
- DEPTH, 8 — sample buffer entries; power of two, ≥2
- DATA_W, 12 — ADC sample width; 9..16
- ADC_TIMEOUT, 1_000_000 — max cycles in CONVERT before abort

Ports:
- clk  in  1  100 MHz system clock
- reset  in  1  synchronous, active-high; one clock, all state sampled on rising edge of clk
- sample_req  in  1  one-cycle pulse (SAMPLE button)
- send_req  in  1  one-cycle pulse (SEND button)
- clear_req  in  1  one-cycle pulse (RESET button)
- adc_start  out  1  one-cycle conversion start pulse
- adc_done  in  1  one-cycle pulse; adc_data valid same cycle
- adc_data  in  DATA_W  conversion result
- tx_start  out  1  one-cycle byte-send pulse
- tx_data  out  8  byte to send, valid while tx_start high
- tx_busy  in  1  UART busy; rises the cycle after tx_start
- count  out  $clog2(DEPTH)+1  samples stored, 0..DEPTH
- last_sample  out  DATA_W  most recent stored sample
- busy  out  1  high in any state other than IDLE
- full  out  1  count == DEPTH
- err  out  1  sticky ADC timeout flag

## Operation
- States: IDLE, CONVERT, SEND_HI, SEND_LO, TX_WAIT.
- All outputs are registered. Reset values are all 0, with state = IDLE. Buffer contents after reset are don't-care.
- IDLE request priority: clear_req > sample_req > send_req. Requests in non-IDLE states are dropped, not queued.
- clear_req (IDLE): count←0, last_sample←0, err←0. State stays IDLE.
- sample_req (IDLE, count<DEPTH): state→CONVERT, adc_start=1 for exactly that next cycle, timeout counter←0.
- sample_req with count==DEPTH: ignored, no adc_start. full is already high.
- CONVERT, adc_done=1: mem[count]←adc_data, last_sample←adc_data, count←count+1, state→IDLE.
- CONVERT, timeout counter reaches ADC_TIMEOUT−1 without adc_done: err←1, state→IDLE, count unchanged.
- adc_done outside CONVERT: ignored.
- send_req (IDLE, count>0): idx←0, state→SEND_HI.
- send_req with count==0: ignored.
- Byte order per sample s=mem[idx]:
  - high byte = zero-extended s[DATA_W-1:8];
  - then low byte = s[7:0].
  - Samples go out oldest first, idx 0..count−1.
- SEND_HI/SEND_LO: when tx_busy==0, pulse tx_start with tx_data, then →TX_WAIT.
- TX_WAIT: ignore tx_busy for the first cycle. Then wait for tx_busy==0:
  - after a high byte → SEND_LO;
  - after a low byte with idx<count−1 → idx+1, SEND_HI;
  - else → IDLE.
- Sending does not modify count or buffer. Repeated SEND re-sends the same data.

## Timing
- sample_req at cycle t → adc_start high at t+1, busy high from t+1.
- adc_done at cycle u → count, last_sample and full update at u+1. busy low at u+1; a new request is accepted at u+1.
- send_req at t → first tx_start no earlier than t+2.
- Minimum spacing between consecutive tx_start pulses is 3 cycles (UART-limited in practice).
- tx_data holds its value from tx_start until the next tx_start.
- Reset mid-operation (CONVERT or any SEND state):
  - next cycle IDLE, all outputs 0;
  - an in-flight adc_done arriving later is ignored;
  - an in-flight UART byte completes in the UART, with no further tx_start.
- Timeout boundary: adc_done on the same cycle as the timeout terminal count is accepted as a valid sample; err stays 0.
- count never wraps. Writes stop at DEPTH.

## Test plan
- Reset, then sample_req with ADC returning 12'hABC after 5 cycles → one adc_start pulse at t+1; count=1, last_sample=12'hABC, busy low one cycle after adc_done.
- Store 12'h123 and 12'h0FF, then send_req with UART busy 10 cycles/byte → tx_data sequence 8'h01, 8'h23, 8'h00, 8'hFF, one tx_start each; count still 2.
- Fill to DEPTH=8, then sample_req → no adc_start, full=1, count=8. Then clear_req → count=0, full=0, last_sample=0.
- ADC_TIMEOUT=16, sample_req with no adc_done → err=1 after 16 cycles in CONVERT, state IDLE, count unchanged. A late adc_done is ignored. clear_req → err=0.
- sample_req, send_req and clear_req all in the same IDLE cycle with count=3 → only clear executes (count=0, no adc_start, no tx_start). send_req during CONVERT is dropped.
- reset asserted during SEND_LO of the second sample → next cycle all outputs 0, no further tx_start. send_req with count=0 → ignored.
